// File: rtl/minmax_stream_if.sv
// Stream-in / result-out bundle for minmax_stream.
// slave = reducer side, master = producer/consumer side.
interface minmax_stream_if #(
    parameter int unsigned W    = 5,
    parameter int unsigned IDXW = 3
);
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            s_last;
    logic            us_sel;
    logic            min_max_sel;
    logic            m_valid;
    logic            m_ready;
    logic [W-1:0]    m_result;
    logic [IDXW-1:0] m_index;
    logic            m_ovf;

    modport slave (
        input  s_valid, s_data, s_last, us_sel, min_max_sel, m_ready,
        output s_ready, m_valid, m_result, m_index, m_ovf
    );

    modport master (
        output s_valid, s_data, s_last, us_sel, min_max_sel, m_ready,
        input  s_ready, m_valid, m_result, m_index, m_ovf
    );
endinterface

// File: rtl/minmax_stream.sv
// Serial min/max reducer: one element per beat, frame ends on s_last,
// result (value, 0-based index, overflow flag) held until taken downstream.
module minmax_stream #(
    parameter int unsigned W      = 5,
    parameter int unsigned NI     = 7,
    parameter int unsigned IDXW   = $clog2(NI),
    parameter int unsigned MM_CFG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    minmax_stream_if.slave   bus
);
    localparam int unsigned PW = $clog2(NI + 1);
    localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

    typedef enum logic [1:0] {ST_FIRST, ST_ACC, ST_OUT} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_val_q, acc_val_d;
    logic [IDXW-1:0] acc_idx_q, acc_idx_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            ovf_q, ovf_d;
    logic            sgn_q, sgn_d;
    logic            max_q, max_d;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic [W-1:0]    m_result_q, m_result_d;
    logic [IDXW-1:0] m_index_q, m_index_d;
    logic            m_ovf_q, m_ovf_d;

    logic            beat;
    logic            in_range;
    logic            better;
    logic            first_max;
    logic [W-1:0]    key_new, key_acc;

    assign beat      = bus.s_valid && s_ready_q;
    assign in_range  = pos_q < PW'(NI);
    assign first_max = (MM_CFG == 0) ? bus.min_max_sel : (MM_CFG == 2);

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign key_new = bus.s_data ^ (sgn_q ? MSB_MASK : '0);
    assign key_acc = acc_val_q  ^ (sgn_q ? MSB_MASK : '0);
    assign better  = max_q ? (key_new > key_acc) : (key_new < key_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FIRST;
            acc_val_q  <= '0;
            acc_idx_q  <= '0;
            pos_q      <= '0;
            ovf_q      <= 1'b0;
            sgn_q      <= 1'b0;
            max_q      <= 1'b0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            m_result_q <= '0;
            m_index_q  <= '0;
            m_ovf_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_val_q  <= acc_val_d;
            acc_idx_q  <= acc_idx_d;
            pos_q      <= pos_d;
            ovf_q      <= ovf_d;
            sgn_q      <= sgn_d;
            max_q      <= max_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_result_q <= m_result_d;
            m_index_q  <= m_index_d;
            m_ovf_q    <= m_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_val_d  = acc_val_q;
        acc_idx_d  = acc_idx_q;
        pos_d      = pos_q;
        ovf_d      = ovf_q;
        sgn_d      = sgn_q;
        max_d      = max_q;
        m_result_d = m_result_q;
        m_index_d  = m_index_q;
        m_ovf_d    = m_ovf_q;

        case (state_q)
            ST_FIRST: begin
                if (beat) begin
                    acc_val_d = bus.s_data;
                    acc_idx_d = '0;
                    pos_d     = PW'(1);
                    ovf_d     = 1'b0;
                    sgn_d     = bus.us_sel;
                    max_d     = first_max;
                    state_d   = bus.s_last ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    // Past NI elements nothing is compared; pos stops at NI.
                    if (in_range) begin
                        if (better) begin
                            acc_val_d = bus.s_data;
                            acc_idx_d = IDXW'(pos_q);
                        end
                        pos_d = pos_q + PW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bus.s_last) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    state_d = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase

        if (beat && bus.s_last) begin
            m_result_d = acc_val_d;
            m_index_d  = acc_idx_d;
            m_ovf_d    = ovf_d;
        end

        s_ready_d = (state_d != ST_OUT);
        m_valid_d = (state_d == ST_OUT);
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_result = m_result_q;
    assign bus.m_index  = m_index_q;
    assign bus.m_ovf    = m_ovf_q;
endmodule
